// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the data-memory arbiter slice: arbitration FSM
// state encoding, read-response owner encoding and default values for the
// starvation limit and FFT burst length.
package cpu_pkg;

  // Arbiter FSM states: S_CPU gives the CPU priority, S_FFT is a forced FFT burst
  typedef enum logic {
    S_CPU = 1'b0,
    S_FFT = 1'b1
  } arb_state_e;

  // Owner of an outstanding read
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_FFT = 1'b1;

  // Default arbitration tuning
  localparam int STARVE_LIM_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

endpackage

// File: rtl/dmem_rsp_router.sv
// dmem_rsp_router
// Remembers which port issued the read in the previous cycle and steers the
// memory's read data back to that port one cycle later.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   issue_rd               a read is issued to memory this cycle
//   issue_id               owner of that read (OWN_CPU / OWN_FFT)
//   mem_rdata              memory read data (valid the cycle after a read)
//   cpu_rvalid, cpu_rdata  CPU read response
//   fft_rvalid, fft_rdata  FFT read response
module dmem_rsp_router
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_rd,
  input  logic              issue_id,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              fft_rvalid,
  output logic [DATA_W-1:0] fft_rdata
);

  logic owner_vld_r;
  logic owner_id_r;

  // Owner tag: one-deep, since the memory returns data exactly one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_vld_r <= 1'b0;
      owner_id_r  <= OWN_CPU;
    end else begin
      owner_vld_r <= issue_rd;
      owner_id_r  <= issue_id;
    end
  end

  // Data is shared; only the owner's valid is raised
  assign cpu_rvalid = owner_vld_r & (owner_id_r == OWN_CPU);
  assign fft_rvalid = owner_vld_r & (owner_id_r == OWN_FFT);
  assign cpu_rdata  = mem_rdata;
  assign fft_rdata  = mem_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-port synchronous data memory between the CPU load/store
// unit (default priority) and the FFT coprocessor. After STARVE_LIM
// consecutive cycles in which the FFT requested but the CPU won, the FFT is
// given a forced burst of up to MAX_BURST grants.
// Ports:
//   clk, reset                                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt             CPU request port and grant
//   cpu_rvalid, cpu_rdata                      CPU read response
//   fft_req/we/addr/wdata, fft_gnt             FFT request port and grant
//   fft_rvalid, fft_rdata                      FFT read response
//   mem_en/we/addr/wdata, mem_rdata            memory interface
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = STARVE_LIM_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fft_req,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  output logic              fft_gnt,
  output logic              fft_rvalid,
  output logic [DATA_W-1:0] fft_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_LIM);
  localparam logic [BC_W-1:0] BURST_TOP  = BC_W'(MAX_BURST);

  arb_state_e      state_r;
  logic [SC_W-1:0] starve_cnt_r;
  logic [BC_W-1:0] burst_cnt_r;
  logic [SC_W-1:0] starve_inc_s;
  logic [BC_W-1:0] burst_inc_s;
  logic            cpu_gnt_s;
  logic            fft_gnt_s;
  logic            issue_rd_s;
  logic            issue_id_s;

  // Saturating next values of the counters
  assign starve_inc_s = (starve_cnt_r == STARVE_TOP) ? STARVE_TOP : starve_cnt_r + SC_W'(1);
  assign burst_inc_s  = (burst_cnt_r == BURST_TOP) ? BURST_TOP : burst_cnt_r + BC_W'(1);

  // Grant decision; gated by reset so nothing is issued while reset is held
  always_comb begin
    cpu_gnt_s = 1'b0;
    fft_gnt_s = 1'b0;
    if (reset) begin
      case (state_r)
        S_CPU: begin
          if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else if (fft_req) begin
            fft_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = 1'b0;
          end
        end
        S_FFT: begin
          if (fft_req) begin
            fft_gnt_s = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else begin
            fft_gnt_s = 1'b0;
          end
        end
        default: begin
          cpu_gnt_s = 1'b0;
          fft_gnt_s = 1'b0;
        end
      endcase
    end else begin
      cpu_gnt_s = 1'b0;
      fft_gnt_s = 1'b0;
    end
  end

  // Memory request mux driven from whichever port holds the grant
  always_comb begin
    mem_en = cpu_gnt_s | fft_gnt_s;
    if (fft_gnt_s) begin
      mem_we    = fft_we;
      mem_addr  = fft_addr;
      mem_wdata = fft_wdata;
    end else begin
      mem_we    = cpu_gnt_s & cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Arbitration FSM with starvation and burst counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_CPU;
      starve_cnt_r <= {SC_W{1'b0}};
      burst_cnt_r  <= {BC_W{1'b0}};
    end else begin
      case (state_r)
        S_CPU: begin
          burst_cnt_r <= {BC_W{1'b0}};
          if (cpu_req && fft_req) begin
            // FFT lost this cycle; switch to a forced burst once the limit is hit
            if (starve_inc_s == STARVE_TOP) begin
              state_r      <= S_FFT;
              starve_cnt_r <= {SC_W{1'b0}};
            end else begin
              starve_cnt_r <= starve_inc_s;
            end
          end else begin
            starve_cnt_r <= {SC_W{1'b0}};
          end
        end
        S_FFT: begin
          starve_cnt_r <= {SC_W{1'b0}};
          if (fft_req) begin
            if (burst_inc_s == BURST_TOP) begin
              state_r     <= S_CPU;
              burst_cnt_r <= {BC_W{1'b0}};
            end else begin
              burst_cnt_r <= burst_inc_s;
            end
          end else begin
            // FFT went idle mid-burst: hand priority straight back to the CPU
            state_r     <= S_CPU;
            burst_cnt_r <= {BC_W{1'b0}};
          end
        end
        default: begin
          state_r      <= S_CPU;
          starve_cnt_r <= {SC_W{1'b0}};
          burst_cnt_r  <= {BC_W{1'b0}};
        end
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign fft_gnt    = fft_gnt_s;
  assign issue_rd_s = (cpu_gnt_s & ~cpu_we) | (fft_gnt_s & ~fft_we);
  assign issue_id_s = fft_gnt_s ? OWN_FFT : OWN_CPU;

  dmem_rsp_router #(
    .DATA_W(DATA_W)
  ) u_rsp_router (
    .clk       (clk),
    .reset     (reset),
    .issue_rd  (issue_rd_s),
    .issue_id  (issue_id_s),
    .mem_rdata (mem_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .fft_rvalid(fft_rvalid),
    .fft_rdata (fft_rdata)
  );

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the CPU's single-port synchronous data memory between the CPU load/store unit and the FFT coprocessor's memory port. The CPU has default priority. A starvation counter forces bounded FFT bursts so butterfly passes always make progress. The block sits between the CPU core, the FFT engine and the data memory instance, and is the only driver of the memory's control inputs.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data word width
- STARVE_LIM, 8, consecutive FFT denials that trigger an FFT burst (≥1)
- MAX_BURST, 4, maximum consecutive forced FFT grants per burst (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cpu_req, cpu_we  in  1, 1  CPU access request and write enable
- cpu_addr, cpu_wdata  in  ADDR_W, DATA_W  CPU address and write data
- cpu_gnt  out  1  CPU access issued this cycle; the CPU stalls while cpu_req=1 and cpu_gnt=0
- cpu_rvalid, cpu_rdata  out  1, DATA_W  CPU read response
- fft_req, fft_we, fft_addr, fft_wdata  in  1, 1, ADDR_W, DATA_W  FFT port, same meaning as the CPU port
- fft_gnt, fft_rvalid, fft_rdata  out  1, 1, DATA_W  FFT grant and read response
- mem_en, mem_we  out  1, 1  memory enable and write enable
- mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address and write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read is issued

## Operation
- At most one access is issued per cycle. In the issue cycle, mem_* is driven combinationally from the granted port and mem_en = cpu_gnt | fft_gnt.
- cpu_gnt and fft_gnt are combinational from the requests, the state and the counters. They are never both high.
- Requester rule: a requester holds req, we, addr and wdata stable until it sees gnt high at a clock edge. It may drop req without being granted.
- FSM has two states, S_CPU (reset state) and S_FFT.
- S_CPU:
  - cpu_req=1: CPU is granted. If fft_req=1 in the same cycle, starve_cnt increments; when starve_cnt reaches STARVE_LIM, the FSM moves to S_FFT with burst_cnt=0 and starve_cnt cleared.
  - cpu_req=0 and fft_req=1: FFT is granted and starve_cnt clears.
  - fft_req=0: starve_cnt clears.
- S_FFT:
  - fft_req=1: FFT is granted regardless of cpu_req, and burst_cnt increments.
  - The FSM returns to S_CPU after the grant that brings burst_cnt to MAX_BURST.
  - If fft_req=0 in S_FFT, the CPU is granted if it is requesting, and the FSM returns to S_CPU in the same cycle.
- Read return: a registered owner tag (owner_vld, owner_id) captures every granted read. The next cycle asserts the owner's rvalid with rdata = mem_rdata. The non-owner's rvalid is 0. rdata is don't-care while rvalid=0.
- Granted writes produce no response.
- starve_cnt saturates at STARVE_LIM. burst_cnt width is $clog2(MAX_BURST+1).

## Timing
- Grant latency is 0 cycles: a request can be granted in the cycle it is asserted. Read data returns exactly 1 cycle after the grant.
- Back-to-back reads from either port are fully pipelined, one per cycle. A response and a new grant can occur in the same cycle.
- Reset asserted (low): state ← S_CPU, starve_cnt = burst_cnt = 0, owner_vld = 0. During reset, cpu_gnt = fft_gnt = mem_en = mem_we = 0 and cpu_rvalid = fft_rvalid = 0.
- Reset mid-operation: any read issued before reset yields no response after reset is released.
- Simultaneous requests with STARVE_LIM=8 and MAX_BURST=4, both requesting continuously: the steady pattern is 8 CPU grants, then 4 FFT grants, repeating.
- A grant whose requester drops req in the same cycle cannot occur, because the grant logic is gated by req.

## Structure
- The shared package (cpu_pkg) holds:
  - the owner encoding OWN_CPU=0 and OWN_FFT=1;
  - the state encoding S_CPU and S_FFT;
  - the defaults for STARVE_LIM and MAX_BURST.
- One natural sub-module, dmem_rsp_router: the registered owner tag plus the rvalid/rdata demultiplexer.
- The FSM, counters and request mux stay in dmem_arbiter.

## Test plan
- Reset, then CPU read of address 0x10 while memory holds 0xDEADBEEF there: cpu_gnt=1 in the issue cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, fft_rvalid=0.
- FFT write of 0x12345678 to 0x20 with the CPU idle: fft_gnt=1 and mem_we=1 in the issue cycle. A following CPU read of 0x20 returns 0x12345678.
- Both ports request reads continuously for 24 cycles: grants follow CPU×8, FFT×4, CPU×8, FFT×4. Each rvalid goes to the correct owner 1 cycle later.
- In S_FFT after 2 burst grants, fft_req drops while cpu_req=1: cpu_gnt=1 that same cycle, state returns to S_CPU, starve_cnt=0.
- Reset asserted one cycle after an FFT read grant: no fft_rvalid ever appears. After release, both gnts are 0 until a request arrives and state is S_CPU.
- Alternating CPU/FFT requests with no overlap: every request is granted in 0 cycles, starve_cnt stays 0, and S_FFT is never entered.
